// File: rtl/sec08_queues_pipe_queue2.sv
`default_nettype none
// ============================================================================
// Module   : sec08_queues_pipe_queue2
// Brief    : Two-entry pipe queue. The input ready is passed through
//            combinationally from the output ready, so a full queue can still
//            accept a message in the cycle its head leaves. There is no data
//            bypass: a new message reaches the output one cycle after enqueue.
// Revision : 1.0 - initial release
// ============================================================================
module sec08_queues_pipe_queue2 #(
  parameter int p_msg_nbits = 32
) (
  input  logic                   clk,
  input  logic                   reset,          // asynchronous, active-low
  input  logic                   istream_val,
  output logic                   istream_rdy,
  input  logic [p_msg_nbits-1:0] istream_msg,
  output logic                   ostream_val,
  input  logic                   ostream_rdy,
  output logic [p_msg_nbits-1:0] ostream_msg,
  output logic [1:0]             num_free_entries
);

  // Control state
  logic [1:0] count_q,   count_d;
  logic       enq_ptr_q, enq_ptr_d;
  logic       deq_ptr_q, deq_ptr_d;

  // Payload storage (deliberately not reset)
  logic [p_msg_nbits-1:0] data_q [2];
  logic [p_msg_nbits-1:0] data_d [2];

  logic enq;
  logic deq;

  // Handshake outputs, derived from registered state plus the ready pass-through
  always_comb begin
    ostream_val      = (count_q != 2'd0);
    // Ready is forced low while reset is held so nothing is accepted then.
    istream_rdy      = reset & ((count_q != 2'd2) | ostream_rdy);
    ostream_msg      = data_q[deq_ptr_q];
    num_free_entries = 2'd2 - count_q;
    enq              = istream_val & istream_rdy;
    deq              = ostream_val & ostream_rdy;
  end

  // Next-state computation for pointers, occupancy and payload entries
  always_comb begin
    count_d   = count_q;
    enq_ptr_d = enq_ptr_q;
    deq_ptr_d = deq_ptr_q;
    data_d[0] = data_q[0];
    data_d[1] = data_q[1];

    if (enq) begin
      data_d[enq_ptr_q] = istream_msg;
      enq_ptr_d         = ~enq_ptr_q;
    end
    if (deq) begin
      deq_ptr_d = ~deq_ptr_q;
    end

    case ({enq, deq})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Control registers, cleared immediately when reset falls
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q   <= 2'd0;
      enq_ptr_q <= 1'b0;
      deq_ptr_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      enq_ptr_q <= enq_ptr_d;
      deq_ptr_q <= deq_ptr_d;
    end
  end

  // Payload registers; contents are meaningless whenever count is zero
  always_ff @(posedge clk) begin
    data_q[0] <= data_d[0];
    data_q[1] <= data_d[1];
  end

endmodule
`default_nettype wire

// File: tb/tb_sec08_queues_pipe_queue2.sv
`default_nettype none
// ============================================================================
// Module   : tb_sec08_queues_pipe_queue2
// Brief    : Directed and random self-checking bench for the pipe queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sec08_queues_pipe_queue2;

  logic        clk;
  logic        reset;
  logic        istream_val;
  logic        istream_rdy;
  logic [31:0] istream_msg;
  logic        ostream_val;
  logic        ostream_rdy;
  logic [31:0] ostream_msg;
  logic [1:0]  num_free_entries;

  int checks   = 0;
  int failures = 0;

  sec08_queues_pipe_queue2 #(.p_msg_nbits(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .istream_val      (istream_val),
    .istream_rdy      (istream_rdy),
    .istream_msg      (istream_msg),
    .ostream_val      (ostream_val),
    .ostream_rdy      (ostream_rdy),
    .ostream_msg      (ostream_msg),
    .num_free_entries (num_free_entries)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] m, input logic r);
    istream_val = v;
    istream_msg = m;
    ostream_rdy = r;
  endtask

  logic [31:0] model_q[$];
  logic [31:0] prev_msg;
  logic        prev_stall;
  logic        exp_rdy;
  logic        m_enq;
  logic        m_deq;
  int          sent;
  int          recv;
  int          cycles;

  initial begin
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    #12;
    // Outputs while reset is held
    chk("rst_ostream_val", {31'b0, ostream_val}, 32'd0);
    chk("rst_istream_rdy", {31'b0, istream_rdy}, 32'd0);
    chk("rst_num_free",    {30'b0, num_free_entries}, 32'd2);
    #10;
    reset = 1'b1;            // released away from the edge
    cyc();

    // ---- single enqueue, no bypass ----
    drive(1'b1, 32'h0000_00AA, 1'b0);
    #1;
    chk("t1_irdy_first",   {31'b0, istream_rdy}, 32'd1);
    chk("t1_oval_same",    {31'b0, ostream_val}, 32'd0);
    chk("t1_nf_before",    {30'b0, num_free_entries}, 32'd2);
    cyc();
    drive(1'b0, 32'h0, 1'b0);
    #1;
    chk("t1_oval_next",    {31'b0, ostream_val}, 32'd1);
    chk("t1_msg_next",     ostream_msg, 32'hAA);
    chk("t1_nf_next",      {30'b0, num_free_entries}, 32'd1);
    ostream_rdy = 1'b1;
    cyc();
    ostream_rdy = 1'b0;
    #1;
    chk("t1_empty",        {31'b0, ostream_val}, 32'd0);

    // ---- fill, ready pass-through, ordering ----
    drive(1'b1, 32'h11, 1'b0);
    cyc();
    drive(1'b1, 32'h22, 1'b0);
    #1;
    chk("t2_irdy_cnt1",    {31'b0, istream_rdy}, 32'd1);
    cyc();
    drive(1'b0, 32'h0, 1'b0);
    #1;
    chk("t2_irdy_full",    {31'b0, istream_rdy}, 32'd0);
    chk("t2_nf_full",      {30'b0, num_free_entries}, 32'd0);
    chk("t2_head_11",      ostream_msg, 32'h11);
    ostream_rdy = 1'b1;
    #1;
    chk("t2_irdy_pass",    {31'b0, istream_rdy}, 32'd1);
    drive(1'b1, 32'h33, 1'b1);
    cyc();
    drive(1'b0, 32'h0, 1'b1);
    #1;
    chk("t2_head_22",      ostream_msg, 32'h22);
    chk("t2_nf_still0",    {30'b0, num_free_entries}, 32'd0);
    cyc();
    #1;
    chk("t2_head_33",      ostream_msg, 32'h33);
    chk("t2_nf_1",         {30'b0, num_free_entries}, 32'd1);
    cyc();
    #1;
    chk("t2_drained",      {31'b0, ostream_val}, 32'd0);
    chk("t2_nf_2",         {30'b0, num_free_entries}, 32'd2);

    // ---- continuous streaming, one per cycle after 1-cycle latency ----
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h100 + 32'(i), 1'b1);
      #1;
      if (i == 0) begin
        chk("t3_oval_lat", {31'b0, ostream_val}, 32'd0);
      end else begin
        chk("t3_oval",     {31'b0, ostream_val}, 32'd1);
        chk("t3_msg",      ostream_msg, 32'h100 + 32'(i - 1));
        chk("t3_nf",       {30'b0, num_free_entries}, 32'd1);
      end
      chk("t3_irdy",       {31'b0, istream_rdy}, 32'd1);
      cyc();
    end
    drive(1'b0, 32'h0, 1'b1);
    #1;
    chk("t3_last",         ostream_msg, 32'h109);
    cyc();
    #1;
    chk("t3_empty",        {31'b0, ostream_val}, 32'd0);

    // ---- random val/rdy with scoreboard ----
    sent       = 0;
    recv       = 0;
    cycles     = 0;
    prev_stall = 1'b0;
    prev_msg   = 32'h0;
    while ((sent < 1000) && (cycles < 20000)) begin
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      #1;
      exp_rdy = (model_q.size() != 2) || ostream_rdy;
      chk("r_oval", {31'b0, ostream_val}, {31'b0, model_q.size() != 0});
      chk("r_irdy", {31'b0, istream_rdy}, {31'b0, exp_rdy});
      chk("r_nf",   {30'b0, num_free_entries}, 32'(2 - model_q.size()));
      if (model_q.size() != 0) chk("r_head", ostream_msg, model_q[0]);
      if (prev_stall) chk("r_stable", ostream_msg, prev_msg);
      m_enq      = istream_val && exp_rdy;
      m_deq      = ostream_rdy && (model_q.size() != 0);
      prev_stall = (model_q.size() != 0) && !ostream_rdy;
      prev_msg   = ostream_msg;
      if (m_deq) begin
        void'(model_q.pop_front());
        recv++;
      end
      if (m_enq) begin
        model_q.push_back(istream_msg);
        sent++;
      end
      cyc();
      cycles++;
    end
    chk("r_budget", {31'b0, sent >= 1000}, 32'd1);
    drive(1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 4 && model_q.size() != 0; k++) begin
      #1;
      chk("r_drain", ostream_msg, model_q[0]);
      void'(model_q.pop_front());
      recv++;
      cyc();
    end
    #1;
    chk("r_count", 32'(recv), 32'(sent));
    chk("r_final_empty", {31'b0, ostream_val}, 32'd0);

    // ---- mid-operation asynchronous reset ----
    drive(1'b1, 32'hC1, 1'b0);
    cyc();
    drive(1'b1, 32'hC2, 1'b0);
    cyc();
    drive(1'b0, 32'h0, 1'b0);
    #1;
    chk("t5_full", {30'b0, num_free_entries}, 32'd0);
    #2;
    reset = 1'b0;             // between edges
    #1;
    chk("t5_rst_oval", {31'b0, ostream_val}, 32'd0);
    chk("t5_rst_nf",   {30'b0, num_free_entries}, 32'd2);
    chk("t5_rst_irdy", {31'b0, istream_rdy}, 32'd0);
    cyc();
    #3;
    reset = 1'b1;
    cyc();
    drive(1'b1, 32'h5A, 1'b0);
    #1;
    chk("t5_irdy_after", {31'b0, istream_rdy}, 32'd1);
    cyc();
    drive(1'b0, 32'h0, 1'b1);
    #1;
    chk("t5_first_out", ostream_msg, 32'h5A);
    chk("t5_nf_after",  {30'b0, num_free_entries}, 32'd1);
    cyc();
    #1;
    chk("t5_empty",     {31'b0, ostream_val}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
